// File: rtl/blsenswr.sv
// Sensor exposure/gain register writer: samples exp/gain on each frame strobe and
// serialises only the changed values as 24-bit write frames over a 3-wire port.
module blsenswr #(
   parameter int unsigned CLKDIV    = 4,
   parameter logic [6:0]  ADDR_EXP  = 7'h09,
   parameter logic [6:0]  ADDR_GAIN = 7'h35
) (
   input  logic        clk,
   input  logic        init,
   input  logic        en,
   input  logic        tv,
   input  logic [10:0] exp,
   input  logic [7:0]  gain,
   output logic        sclk,
   output logic        sdata,
   output logic        scs_n,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_e;

   localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
   localparam logic [4:0] BIT_LAST = 5'd23;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        phase_q, phase_d;
   logic [4:0]  bit_q, bit_d;
   logic [23:0] shreg_q, shreg_d;
   logic        tv_d_q, tv_d_d;
   logic [10:0] sh_exp_q, sh_exp_d;
   logic [7:0]  sh_gain_q, sh_gain_d;
   logic [10:0] last_exp_q, last_exp_d;
   logic [7:0]  last_gain_q, last_gain_d;
   logic        pend_exp_q, pend_exp_d;
   logic        pend_gain_q, pend_gain_d;
   logic        wr_exp_q, wr_exp_d;
   logic        wr_gain_q, wr_gain_d;
   logic        valid_q, valid_d;
   logic        sclk_q, sclk_d;
   logic        sdata_q, sdata_d;
   logic        scs_n_q, scs_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        tv_edge;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      sh_exp_d    = sh_exp_q;
      sh_gain_d   = sh_gain_q;
      last_exp_d  = last_exp_q;
      last_gain_d = last_gain_q;
      pend_exp_d  = pend_exp_q;
      pend_gain_d = pend_gain_q;
      wr_exp_d    = wr_exp_q;
      wr_gain_d   = wr_gain_q;
      tv_d_d      = tv;
      tv_edge     = tv & ~tv_d_q & en;

      unique case (state_q)
         IDLE: begin
            if (pend_exp_q || pend_gain_q) state_d = LOAD;
         end
         LOAD: begin
            if (pend_exp_q) begin
               shreg_d    = {1'b1, ADDR_EXP, 5'b0, sh_exp_q};
               pend_exp_d = 1'b0;
               last_exp_d = sh_exp_q;
               wr_exp_d   = 1'b1;
            end else begin
               shreg_d     = {1'b1, ADDR_GAIN, 8'b0, sh_gain_q};
               pend_gain_d = 1'b0;
               last_gain_d = sh_gain_q;
               wr_gain_d   = 1'b1;
            end
            cnt_d   = '0;
            phase_d = 1'b0;
            bit_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  // The last bit stays on sdata through HOLD instead of shifting out.
                  if (bit_q == BIT_LAST) begin
                     state_d = HOLD;
                  end else begin
                     bit_d   = bit_q + 5'd1;
                     shreg_d = {shreg_q[22:0], 1'b0};
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = '0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         GAP: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = '0;
               state_d = (pend_exp_q || pend_gain_q) ? LOAD : IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      valid_d = wr_exp_d & wr_gain_d;

      // Compared against the post-LOAD last values so a same-cycle load is not re-queued.
      if (tv_edge) begin
         sh_exp_d    = exp;
         sh_gain_d   = gain;
         pend_exp_d  = ~valid_d | (exp != last_exp_d);
         pend_gain_d = ~valid_d | (gain != last_gain_d);
      end

      scs_n_d = ~((state_d == LOAD) || (state_d == SHIFT) || (state_d == HOLD));
      sclk_d  = (state_d == SHIFT) & phase_d;
      sdata_d = scs_n_d ? 1'b0 : shreg_d[23];
      busy_d  = (state_d != IDLE);
      done_d  = (state_q == GAP) && (state_d == IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         phase_q     <= 1'b0;
         bit_q       <= '0;
         shreg_q     <= '0;
         tv_d_q      <= 1'b0;
         sh_exp_q    <= '0;
         sh_gain_q   <= '0;
         last_exp_q  <= '0;
         last_gain_q <= '0;
         pend_exp_q  <= 1'b0;
         pend_gain_q <= 1'b0;
         wr_exp_q    <= 1'b0;
         wr_gain_q   <= 1'b0;
         valid_q     <= 1'b0;
         sclk_q      <= 1'b0;
         sdata_q     <= 1'b0;
         scs_n_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         tv_d_q      <= tv_d_d;
         sh_exp_q    <= sh_exp_d;
         sh_gain_q   <= sh_gain_d;
         last_exp_q  <= last_exp_d;
         last_gain_q <= last_gain_d;
         pend_exp_q  <= pend_exp_d;
         pend_gain_q <= pend_gain_d;
         wr_exp_q    <= wr_exp_d;
         wr_gain_q   <= wr_gain_d;
         valid_q     <= valid_d;
         sclk_q      <= sclk_d;
         sdata_q     <= sdata_d;
         scs_n_q     <= scs_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign sclk  = sclk_q;
   assign sdata = sdata_q;
   assign scs_n = scs_n_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule
